// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
//
// Takes the EX/MEM slot (effective address, store data, funct3, load/store
// flags). It performs a byte, half or word access over a variable-latency
// req/ack data-memory port. It returns aligned, sign- or zero-extended load
// data toward MEM/WB, and freezes the upstream pipeline while an access is
// outstanding.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   ex_valid          EX/MEM slot holds a valid instruction
//   mem_read          load request
//   mem_write         store request (a load wins if both are set)
//   funct3            000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr              effective address
//   store_data        forwarded rs2
//   dmem_req          request, held until dmem_ack
//   dmem_we           1 = write
//   dmem_addr         word address, bits [1:0] = 0
//   dmem_wdata        lane-replicated store data
//   dmem_wstrb        byte enables
//   dmem_rdata        read word, valid with dmem_ack
//   dmem_ack          access complete
//   load_data         aligned/extended load result
//   mem_stall         freeze IF..EX/MEM this cycle
//   mem_fault         misaligned or illegal funct3; access suppressed
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access outstanding; a valid, non-faulting access starts one
// BUSY  | request on the port, waiting for dmem_ack
// DONE  | access finished, stall released for exactly one cycle

module mem_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic [DATA_W-1:0] dmem_rdata,
   input  logic              dmem_ack,
   output logic [DATA_W-1:0] load_data,
   output logic              mem_stall,
   output logic              mem_fault
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic              access;
   logic              is_load;
   logic              illegal_f3;
   logic              misaligned;
   logic              fault_raw;
   logic              start;
   logic [3:0]        strb_nxt;
   logic [DATA_W-1:0] wdata_nxt;

   logic [2:0]        f3_q;
   logic [1:0]        addr_lo_q;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;
   logic [DATA_W-1:0] load_ext;

   // ------------------------------------------------------------------
   // Access decode and fault detection
   // ------------------------------------------------------------------
   assign access     = ex_valid & (mem_read | mem_write);
   assign is_load    = mem_read;
   assign illegal_f3 = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
   // funct3[1:0] gives the access size for loads and stores alike
   assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                       ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
   assign fault_raw  = illegal_f3 | misaligned;

   // Once BUSY, the slot is frozen and its flags no longer matter
   assign mem_fault  = (state == IDLE) & access & fault_raw;
   assign start      = (state == IDLE) & access & ~fault_raw;
   assign mem_stall  = start | (state == BUSY);
   assign dmem_req   = (state == BUSY);

   // ------------------------------------------------------------------
   // Store lane steering
   // ------------------------------------------------------------------
   always_comb begin
      strb_nxt  = 4'b1111;
      wdata_nxt = store_data;
      case (funct3[1:0])
         2'b00: begin
            strb_nxt  = 4'b0001 << addr[1:0];
            wdata_nxt = {(DATA_W/8){store_data[7:0]}};
         end
         2'b01: begin
            strb_nxt  = 4'b0011 << addr[1:0];
            wdata_nxt = {(DATA_W/16){store_data[15:0]}};
         end
         default: begin
            strb_nxt  = 4'b1111;
            wdata_nxt = store_data;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Load extraction from the returned word
   // ------------------------------------------------------------------
   always_comb begin
      rd_byte = dmem_rdata[7:0];
      case (addr_lo_q)
         2'd0:    rd_byte = dmem_rdata[7:0];
         2'd1:    rd_byte = dmem_rdata[15:8];
         2'd2:    rd_byte = dmem_rdata[23:16];
         default: rd_byte = dmem_rdata[31:24];
      endcase
      rd_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
   end

   always_comb begin
      load_ext = dmem_rdata;
      case (f3_q)
         3'b000:  load_ext = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
         3'b001:  load_ext = {{(DATA_W-16){rd_half[15]}}, rd_half};
         3'b100:  load_ext = {{(DATA_W-8){1'b0}}, rd_byte};
         3'b101:  load_ext = {{(DATA_W-16){1'b0}}, rd_half};
         default: load_ext = dmem_rdata;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)    state_nxt = BUSY;
         BUSY:    if (dmem_ack) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Request and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         dmem_wstrb <= 4'b0000;
         f3_q       <= 3'b000;
         addr_lo_q  <= 2'b00;
         load_data  <= '0;
      end else begin
         if (start) begin
            dmem_we    <= ~is_load;
            dmem_addr  <= {addr[DATA_W-1:2], 2'b00};
            dmem_wdata <= wdata_nxt;
            dmem_wstrb <= strb_nxt;
            f3_q       <= funct3;
            addr_lo_q  <= addr[1:0];
         end
         if ((state == BUSY) && dmem_ack && !dmem_we) begin
            load_data <= load_ext;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads of every size/sign, stores with
// lane steering, fault suppression, delayed ack with a toggling address,
// and async reset in the middle of an access.

module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic [31:0] load_data;
   logic        mem_stall;
   logic        mem_fault;

   int n_checks = 0;
   int n_pass   = 0;

   mem_stage #(.DATA_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ex_valid   (ex_valid),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_wstrb (dmem_wstrb),
      .dmem_rdata (dmem_rdata),
      .dmem_ack   (dmem_ack),
      .load_data  (load_data),
      .mem_stall  (mem_stall),
      .mem_fault  (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one access from IDLE through DONE. The ack is given on the
   // (delay+1)-th request cycle. While the request is outstanding, the
   // upper address bits are toggled to show they have no effect. Returns
   // in the cycle after DONE, with the slot inputs still showing this
   // access, so the next call gives back-to-back traffic.
   task automatic do_access(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rdata, input int delay,
                            input logic [31:0] exp_load, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
      int  stall_cnt;
      int  req_cnt;
      bit  addr_bad;
      bit  done;
      logic [31:0] exp_addr;
      stall_cnt = 0;
      req_cnt   = 0;
      addr_bad  = 0;
      done      = 0;
      exp_addr  = {a[31:2], 2'b00};
      ex_valid   = 1'b1;
      mem_read   = ~we;
      mem_write  = we;
      funct3     = f3;
      addr       = a;
      store_data = sd;
      dmem_ack   = 1'b0;
      #1;
      for (int cyc = 0; cyc < 32 && !done; cyc++) begin
         if (mem_stall) stall_cnt++;
         if (dmem_req) begin
            req_cnt++;
            if (dmem_addr !== exp_addr) addr_bad = 1;
            if (req_cnt == delay + 1) begin
               dmem_ack   = 1'b1;
               dmem_rdata = rdata;
            end
         end else if (cyc > 0) begin
            done = 1;
         end
         if (!done) begin
            tick();
            dmem_ack = 1'b0;
            if (dmem_req) addr = addr ^ 32'h00ff_0000;
            #1;
         end
      end
      if (!done) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_stall_cycles"}, stall_cnt, delay + 2);
         chk({tag, "_req_cycles"}, req_cnt, delay + 1);
         chk({tag, "_addr_stable"}, {31'd0, addr_bad}, 32'd0);
         chk({tag, "_done_load"}, load_data, exp_load);
         chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, we});
         if (we) begin
            chk({tag, "_strb"}, {28'd0, dmem_wstrb}, {28'd0, exp_strb});
            chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
         end
      end
      tick();
   endtask

   initial begin
      rst_n      = 1'b0;
      ex_valid   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      funct3     = 3'b000;
      addr       = 32'd0;
      store_data = 32'd0;
      dmem_rdata = 32'd0;
      dmem_ack   = 1'b0;
      #2;
      chk("rst_req",   {31'd0, dmem_req},  32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_fault", {31'd0, mem_fault}, 32'd0);
      chk("rst_load",  load_data, 32'd0);
      chk("rst_daddr", dmem_addr, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // LW 0x100, ack with the first request cycle; stall at presentation
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      funct3 = 3'b010; addr = 32'h100;
      #1;
      chk("lw_first_stall", {31'd0, mem_stall}, 32'd1);
      chk("lw_first_noreq", {31'd0, dmem_req},  32'd0);
      do_access("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'h0, 32'h0);
      do_access("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0, 32'hFFFFFF80, 4'h0, 32'h0);
      do_access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80112233, 0, 32'h00000080, 4'h0, 32'h0);
      do_access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80112233, 1, 32'h00008011, 4'h0, 32'h0);
      do_access("lh",  1'b0, 3'b001, 32'h102, 32'h0, 32'h80112233, 0, 32'hFFFF8011, 4'h0, 32'h0);
      do_access("lb0", 1'b0, 3'b000, 32'h101, 32'h0, 32'h80112233, 0, 32'h00000022, 4'h0, 32'h0);
      do_access("lh0", 1'b0, 3'b001, 32'h100, 32'h0, 32'h8011A233, 0, 32'hFFFFA233, 4'h0, 32'h0);

      // Stores leave load_data alone; rdata is garbage and must be ignored
      do_access("sh",  1'b1, 3'b001, 32'h206, 32'h0000ABCD, 32'h55555555, 0, 32'hFFFFA233, 4'b1100, 32'hABCDABCD);
      chk("sh_daddr", dmem_addr, 32'h204);
      do_access("sb",  1'b1, 3'b000, 32'h101, 32'h12345678, 32'h55555555, 2, 32'hFFFFA233, 4'b0010, 32'h78787878);
      do_access("sw",  1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h55555555, 0, 32'hFFFFA233, 4'b1111, 32'hCAFEF00D);

      // Faults: no request, no stall, load_data untouched
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      funct3 = 3'b010; addr = 32'h101;
      #1;
      chk("lw_mis_fault", {31'd0, mem_fault}, 32'd1);
      chk("lw_mis_stall", {31'd0, mem_stall}, 32'd0);
      tick();
      chk("lw_mis_noreq", {31'd0, dmem_req}, 32'd0);
      funct3 = 3'b011; addr = 32'h100;
      #1;
      chk("f3_011_fault", {31'd0, mem_fault}, 32'd1);
      tick();
      chk("f3_011_noreq", {31'd0, dmem_req}, 32'd0);
      mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b001; addr = 32'h203;
      #1;
      chk("sh_mis_fault", {31'd0, mem_fault}, 32'd1);
      tick();
      chk("sh_mis_noreq", {31'd0, dmem_req}, 32'd0);
      chk("fault_load_kept", load_data, 32'hFFFFA233);
      ex_valid = 1'b0;
      #1;
      chk("idle_nofault", {31'd0, mem_fault}, 32'd0);

      // Delayed ack: 4 request cycles, 5 stall cycles, address held
      do_access("lw_dly", 1'b0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 3, 32'h13579BDF, 4'h0, 32'h0);

      // Reset in the middle of BUSY
      ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
      funct3 = 3'b010; addr = 32'h400;
      tick();
      chk("abort_busy_req", {31'd0, dmem_req}, 32'd1);
      ex_valid = 1'b0; mem_read = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_req_drop", {31'd0, dmem_req},  32'd0);
      chk("abort_daddr",    dmem_addr, 32'd0);
      chk("abort_load",     load_data, 32'd0);
      chk("abort_stall",    {31'd0, mem_stall}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      // late ack from the aborted access arrives while idle
      dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
      tick();
      dmem_ack = 1'b0;
      #1;
      chk("late_ack_req",  {31'd0, dmem_req}, 32'd0);
      chk("late_ack_load", load_data, 32'd0);
      tick();
      do_access("lw_post", 1'b0, 3'b010, 32'h108, 32'h0, 32'h0BADF00D, 1, 32'h0BADF00D, 4'h0, 32'h0);

      ex_valid = 1'b0; mem_read = 1'b0;
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
